ip_codma_write_machine: RTL and testbench

- Bus-master write engine of the CODMA; counterpart of the read machine.
- Takes a staged buffer of up to 8 x 32-bit words, requests the system bus and bursts the words to memory as 64-bit beats.
- Reports done, busy and error to the DMA control FSM.

---
 rtl/ip_codma_write_machine.sv | 189 ++++++++++++++++++
 tb/tb_ip_codma_write_machine.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_codma_write_machine.sv
// CODMA write machine: requests the system bus and bursts a staged 8 x 32-bit buffer as 64-bit beats.
// Optional grant-wait timeout is enabled by defining CODMA_WR_TIMEOUT_EN.
module ip_codma_write_machine #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         need_write_i,
    input  logic         stop_i,
    input  logic [31:0]  wr_addr_i,
    input  logic [3:0]   wr_size_i,
    input  logic [255:0] data_reg_i,
    output logic         done_o,
    output logic         busy_o,
    output logic         wr_state_error_o,
    output logic         bus_req_o,
    input  logic         bus_grant_i,
    output logic         bus_write_o,
    output logic [31:0]  bus_addr_o,
    output logic [3:0]   bus_size_o,
    output logic [63:0]  bus_write_data_o,
    output logic         bus_write_valid_o,
    input  logic         bus_write_ready_i,
    input  logic         bus_error_i
);

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ASK,
        WR_GRANTED,
        WR_UNUSED
    } wr_state_t;

    wr_state_t      state_q, state_next;
    logic [31:0]    addr_q;
    logic [3:0]     size_q;
    logic [255:0]   data_q;
    logic [2:0]     cnt_q;
    logic [2:0]     last_cnt;
    logic           done_q;
    logic           error_q;
    logic           beat_accept;
    logic           last_beat;
    logic           start_legal;
    logic           timeout;

`ifdef CODMA_WR_TIMEOUT_EN
    logic [CNT_W-1:0] wait_q;

    assign timeout = (state_q == WR_ASK) && !bus_grant_i &&
                     (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts consecutive ungranted WR_ASK cycles; any exit from WR_ASK clears it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wait_q <= '0;
        end else if (state_q == WR_ASK && state_next == WR_ASK) begin
            wait_q <= wait_q + 1'b1;
        end else begin
            wait_q <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Word index of the final beat for each legal burst code (size 9 is the default).
    always_comb begin
        case (size_q)
            4'd3:    last_cnt = 3'd0;
            4'd8:    last_cnt = 3'd4;
            default: last_cnt = 3'd6;
        endcase
    end

    assign beat_accept = (state_q == WR_GRANTED) && bus_write_ready_i;
    assign last_beat   = (cnt_q == last_cnt);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= WR_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Bus error outranks stop, which outranks every ordinary transition.
    always_comb begin
        state_next  = state_q;
        start_legal = 1'b0;
        case (state_q)
            WR_IDLE: begin
                if (need_write_i) begin
                    if (wr_size_i == 4'd3 || wr_size_i == 4'd8 || wr_size_i == 4'd9) begin
                        state_next  = WR_ASK;
                        start_legal = 1'b1;
                    end else begin
                        state_next = WR_UNUSED;
                    end
                end
            end
            WR_ASK: begin
                if (bus_grant_i) begin
                    state_next = WR_GRANTED;
                end else if (timeout) begin
                    state_next = WR_IDLE;
                end
            end
            WR_GRANTED: begin
                if (beat_accept && last_beat) begin
                    state_next = WR_IDLE;
                end
            end
            WR_UNUSED: state_next = WR_IDLE;
            default:   state_next = WR_IDLE;
        endcase
        if (stop_i) begin
            state_next  = WR_IDLE;
            start_legal = 1'b0;
        end
        if (bus_error_i && state_q != WR_IDLE) begin
            state_next  = WR_IDLE;
            start_legal = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q  <= '0;
            size_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q <= beat_accept && last_beat && !stop_i && !bus_error_i;

            if (bus_error_i && state_q != WR_IDLE) begin
                error_q <= 1'b1;
            end else if (stop_i) begin
                error_q <= error_q;
            end else if (timeout || state_q == WR_UNUSED) begin
                error_q <= 1'b1;
            end else if (start_legal) begin
                error_q <= 1'b0;
            end

            if (stop_i) begin
                addr_q <= '0;
                size_q <= '0;
                data_q <= '0;
            end else if (start_legal) begin
                addr_q <= wr_addr_i;
                size_q <= wr_size_i;
                data_q <= data_reg_i;
            end

            if (state_next == WR_IDLE) begin
                cnt_q <= '0;
            end else if (beat_accept) begin
                cnt_q <= cnt_q + 3'd2;
            end
        end
    end

    always_comb begin
        done_o            = done_q;
        wr_state_error_o  = error_q;
        busy_o            = (state_q != WR_IDLE);
        bus_req_o         = 1'b0;
        bus_write_o       = 1'b0;
        bus_addr_o        = '0;
        bus_size_o        = '0;
        bus_write_data_o  = '0;
        bus_write_valid_o = 1'b0;
        if (state_q == WR_ASK || state_q == WR_GRANTED) begin
            bus_req_o   = 1'b1;
            bus_write_o = 1'b1;
            bus_addr_o  = addr_q;
            bus_size_o  = size_q;
        end
        if (state_q == WR_GRANTED) begin
            bus_write_valid_o = 1'b1;
            bus_write_data_o  = data_q[{cnt_q, 5'd0} +: 64];
        end
    end

endmodule

// File: tb/tb_ip_codma_write_machine.sv
// Scoreboard bench for ip_codma_write_machine: expected beats are queued at start and popped as the bus accepts them.
// Define CODMA_WR_TIMEOUT_EN to exercise the grant-wait timeout.
module tb_ip_codma_write_machine;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         need_write_i;
    logic         stop_i;
    logic [31:0]  wr_addr_i;
    logic [3:0]   wr_size_i;
    logic [255:0] data_reg_i;
    logic         done_o;
    logic         busy_o;
    logic         wr_state_error_o;
    logic         bus_req_o;
    logic         bus_grant_i;
    logic         bus_write_o;
    logic [31:0]  bus_addr_o;
    logic [3:0]   bus_size_o;
    logic [63:0]  bus_write_data_o;
    logic         bus_write_valid_o;
    logic         bus_write_ready_i;
    logic         bus_error_i;

    int           check_count = 0;
    int           pass_count  = 0;
    int           done_seen   = 0;
    int           done_mark;
    logic [63:0]  exp_q[$];
    logic [31:0]  cur_addr;
    logic [255:0] buf_v;
    logic [63:0]  held_beat;

    always #5 clk = ~clk;

    ip_codma_write_machine #(
        .TIMEOUT_CYCLES(16),
        .CNT_W(8)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .need_write_i(need_write_i),
        .stop_i(stop_i),
        .wr_addr_i(wr_addr_i),
        .wr_size_i(wr_size_i),
        .data_reg_i(data_reg_i),
        .done_o(done_o),
        .busy_o(busy_o),
        .wr_state_error_o(wr_state_error_o),
        .bus_req_o(bus_req_o),
        .bus_grant_i(bus_grant_i),
        .bus_write_o(bus_write_o),
        .bus_addr_o(bus_addr_o),
        .bus_size_o(bus_size_o),
        .bus_write_data_o(bus_write_data_o),
        .bus_write_valid_o(bus_write_valid_o),
        .bus_write_ready_i(bus_write_ready_i),
        .bus_error_i(bus_error_i)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end else begin
            pass_count++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one start request for a cycle and queues the beats a legal burst should produce.
    task automatic applyStimulus(input logic [3:0] size, input logic [31:0] addr, input logic [255:0] words);
        int nbeats;
        nbeats = (size == 4'd3) ? 1 : (size == 4'd8) ? 3 : (size == 4'd9) ? 4 : 0;
        for (int b = 0; b < nbeats; b++) begin
            exp_q.push_back(words[64*b +: 64]);
        end
        cur_addr     = addr;
        wr_size_i    = size;
        wr_addr_i    = addr;
        data_reg_i   = words;
        need_write_i = 1'b1;
        tick();
        need_write_i = 1'b0;
    endtask

    function automatic logic [255:0] randomWords();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) begin
            w[32*i +: 32] = $urandom;
        end
        return w;
    endfunction

    always @(negedge clk) begin
        if (!reset_i && bus_write_valid_o && bus_write_ready_i) begin
            if (exp_q.size() == 0) begin
                checkOutput("beat_unexpected", 64'd1, 64'd0);
            end else begin
                checkOutput("beat_data", bus_write_data_o, exp_q.pop_front());
                checkOutput("beat_addr", {32'd0, bus_addr_o}, {32'd0, cur_addr});
            end
        end
        if (done_o) begin
            done_seen++;
        end
    end

    initial begin
        reset_i           = 1'b1;
        need_write_i      = 1'b0;
        stop_i            = 1'b0;
        wr_addr_i         = '0;
        wr_size_i         = '0;
        data_reg_i        = '0;
        bus_grant_i       = 1'b0;
        bus_write_ready_i = 1'b1;
        bus_error_i       = 1'b0;
        repeat (2) tick();
        checkOutput("reset_busy", {63'd0, busy_o}, 64'd0);
        checkOutput("reset_req", {63'd0, bus_req_o}, 64'd0);
        checkOutput("reset_err", {63'd0, wr_state_error_o}, 64'd0);
        checkOutput("reset_done", {63'd0, done_o}, 64'd0);
        reset_i = 1'b0;
        tick();

        // Size 9, words 0..7, grant in cycle 3: beats in cycles 4-7, done in cycle 8.
        for (int i = 0; i < 8; i++) buf_v[32*i +: 32] = i;
        done_mark = done_seen;
        applyStimulus(4'd9, 32'h1000, buf_v);
        checkOutput("t1_req_c1", {63'd0, bus_req_o}, 64'd1);
        checkOutput("t1_write_c1", {63'd0, bus_write_o}, 64'd1);
        checkOutput("t1_addr_c1", {32'd0, bus_addr_o}, 64'h1000);
        checkOutput("t1_size_c1", {60'd0, bus_size_o}, 64'd9);
        tick();
        tick();
        bus_grant_i = 1'b1;
        checkOutput("t1_valid_c3", {63'd0, bus_write_valid_o}, 64'd0);
        tick();
        bus_grant_i = 1'b0;
        checkOutput("t1_valid_c4", {63'd0, bus_write_valid_o}, 64'd1);
        checkOutput("t1_data_c4", bus_write_data_o, 64'h00000001_00000000);
        repeat (3) tick();
        checkOutput("t1_data_c7", bus_write_data_o, 64'h00000007_00000006);
        tick();
        checkOutput("t1_done_c8", {63'd0, done_o}, 64'd1);
        checkOutput("t1_busy_c8", {63'd0, busy_o}, 64'd0);
        tick();
        checkOutput("t1_done_c9", {63'd0, done_o}, 64'd0);
        checkOutput("t1_q_empty", exp_q.size(), 64'd0);
        checkOutput("t1_done_cnt", done_seen - done_mark, 64'd1);

        // Size 3 with ready low for two cycles on the only beat.
        buf_v = randomWords();
        bus_write_ready_i = 1'b0;
        done_mark = done_seen;
        applyStimulus(4'd3, 32'h2000_0040, buf_v);
        bus_grant_i = 1'b1;
        tick();
        bus_grant_i = 1'b0;
        held_beat = buf_v[63:0];
        checkOutput("t2_data_wait1", bus_write_data_o, held_beat);
        tick();
        checkOutput("t2_data_wait2", bus_write_data_o, held_beat);
        checkOutput("t2_valid_wait2", {63'd0, bus_write_valid_o}, 64'd1);
        bus_write_ready_i = 1'b1;
        tick();
        checkOutput("t2_done", {63'd0, done_o}, 64'd1);
        checkOutput("t2_busy", {63'd0, busy_o}, 64'd0);
        tick();
        checkOutput("t2_q_empty", exp_q.size(), 64'd0);
        checkOutput("t2_done_cnt", done_seen - done_mark, 64'd1);

        // Size 8 with a bus error during the second beat.
        buf_v = randomWords();
        done_mark = done_seen;
        applyStimulus(4'd8, 32'h0000_8000, buf_v);
        bus_grant_i = 1'b1;
        tick();
        bus_grant_i = 1'b0;
        tick();
        bus_error_i = 1'b1;
        tick();
        bus_error_i = 1'b0;
        checkOutput("t3_busy", {63'd0, busy_o}, 64'd0);
        checkOutput("t3_err", {63'd0, wr_state_error_o}, 64'd1);
        checkOutput("t3_req", {63'd0, bus_req_o}, 64'd0);
        repeat (3) tick();
        checkOutput("t3_no_done", done_seen - done_mark, 64'd0);
        checkOutput("t3_err_sticky", {63'd0, wr_state_error_o}, 64'd1);
        exp_q.delete();
        applyStimulus(4'd9, 32'h0000_9000, randomWords());
        checkOutput("t3_err_cleared", {63'd0, wr_state_error_o}, 64'd0);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        checkOutput("t3_stop_idle", {63'd0, busy_o}, 64'd0);
        exp_q.delete();

        // Illegal size 5: one WR_UNUSED cycle, then error, never a bus request.
        done_mark = done_seen;
        applyStimulus(4'd5, 32'h0000_A000, randomWords());
        checkOutput("t4_busy_unused", {63'd0, busy_o}, 64'd1);
        checkOutput("t4_req_unused", {63'd0, bus_req_o}, 64'd0);
        tick();
        checkOutput("t4_busy_after", {63'd0, busy_o}, 64'd0);
        checkOutput("t4_req_after", {63'd0, bus_req_o}, 64'd0);
        checkOutput("t4_err", {63'd0, wr_state_error_o}, 64'd1);
        checkOutput("t4_no_done", done_seen - done_mark, 64'd0);

        // Stop coincides with the last accepted beat; need_write while busy is dropped.
        buf_v = randomWords();
        done_mark = done_seen;
        applyStimulus(4'd9, 32'h0000_B000, buf_v);
        bus_grant_i = 1'b1;
        tick();
        bus_grant_i  = 1'b0;
        need_write_i = 1'b1;
        tick();
        need_write_i = 1'b0;
        tick();
        tick();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        checkOutput("t5_busy", {63'd0, busy_o}, 64'd0);
        checkOutput("t5_done", {63'd0, done_o}, 64'd0);
        checkOutput("t5_err", {63'd0, wr_state_error_o}, 64'd0);
        tick();
        checkOutput("t5_not_queued", {63'd0, busy_o}, 64'd0);
        checkOutput("t5_q_empty", exp_q.size(), 64'd0);
        checkOutput("t5_no_done", done_seen - done_mark, 64'd0);

`ifdef CODMA_WR_TIMEOUT_EN
        // Grant withheld: 16 cycles in WR_ASK, then the request drops with an error.
        applyStimulus(4'd3, 32'h0000_C000, randomWords());
        repeat (15) tick();
        checkOutput("t6_req_c16", {63'd0, bus_req_o}, 64'd1);
        tick();
        checkOutput("t6_req_dropped", {63'd0, bus_req_o}, 64'd0);
        checkOutput("t6_err", {63'd0, wr_state_error_o}, 64'd1);
        exp_q.delete();
`else
        // Grant withheld: the request stays up until stopped.
        applyStimulus(4'd3, 32'h0000_C000, randomWords());
        repeat (40) tick();
        checkOutput("t6_req_waiting", {63'd0, bus_req_o}, 64'd1);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        checkOutput("t6_req_stopped", {63'd0, bus_req_o}, 64'd0);
        exp_q.delete();
`endif

        // Asynchronous reset in the middle of a burst.
        done_mark = done_seen;
        applyStimulus(4'd9, 32'h0000_D000, randomWords());
        bus_grant_i = 1'b1;
        tick();
        bus_grant_i = 1'b0;
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("t7_busy_async", {63'd0, busy_o}, 64'd0);
        checkOutput("t7_valid_async", {63'd0, bus_write_valid_o}, 64'd0);
        exp_q.delete();
        tick();
        reset_i = 1'b0;
        tick();
        checkOutput("t7_no_done", done_seen - done_mark, 64'd0);
        checkOutput("t7_idle", {63'd0, busy_o}, 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
